spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 2, SHALL set the SPI_clk half-period in CLK cycles; legal values are 1 to 255.
REQ-002 Port CLK, input, 1 bit, SHALL be the single system clock; all logic is rising-edge triggered.
REQ-003 Port Reset, input, 1 bit, SHALL be a synchronous, active-low reset.
REQ-004 Port Start, input, 1 bit, SHALL be an active-low transfer request, level-sensitive.
REQ-005 Port T_Data, input, 8 bits, SHALL carry the transmit byte.
REQ-006 Port T_Ready, input, 1 bit, SHALL be the active-high strobe that loads T_Data.
REQ-007 Ports CPOL and CPHA, input, 1 bit each, SHALL select the SPI mode (idle clock level; sampling phase).
REQ-008 Port MISO, input, 1 bit, SHALL be serial data from the slave.
REQ-009 Port MOSI, output, 1 bit, SHALL be serial data to the slave.
REQ-010 Port SPI_clk, output, 1 bit, SHALL be the serial clock; the net is named exactly SPI_clk.
REQ-011 Port SS_n, output, 1 bit, SHALL be the active-low slave select.
REQ-012 Port Busy, output, 1 bit, SHALL be high whenever the state is not IDLE.
REQ-013 Port R_Data, output, 8 bits, SHALL hold the last received byte.
REQ-014 Port R_Valid, output, 1 bit, SHALL pulse for one CLK at the end of each transfer.

Function
REQ-015 The transmit holding register SHALL load T_Data on every CLK edge where T_Ready=1 and the state is IDLE; T_Ready is ignored otherwise.
REQ-016 The FSM SHALL have states IDLE, SETUP, XFER and DONE.
- IDLE -> SETUP when Start=0.
- SETUP lasts one half-period.
- XFER lasts 16 half-periods.
- XFER -> DONE.
- DONE -> IDLE when Start=1.
REQ-017 Start held low in DONE SHALL NOT retrigger a transfer; Start must return high first.
REQ-018 On entry to SETUP, the FSM SHALL copy the holding register into the shift register and assert SS_n=0.
REQ-019 In IDLE, SETUP and DONE, SPI_clk SHALL equal CPOL.
REQ-020 In XFER, SPI_clk SHALL toggle every CLK_DIV CLK cycles, giving exactly 8 leading and 8 trailing edges.
REQ-021 Data SHALL be sent LSB first.
REQ-022 With CPHA=0:
- MOSI presents bit 0 from SETUP entry.
- MISO is sampled on leading edges.
- MOSI advances on trailing edges.
- MOSI is stable for at least one CLK after each leading edge.
REQ-023 With CPHA=1:
- MOSI advances on leading edges.
- MISO is sampled on trailing edges.
REQ-024 Received bits SHALL fill R_Data LSB first.
REQ-025 R_Data SHALL update and R_Valid SHALL pulse on the CLK edge entering DONE.
REQ-026 SS_n SHALL deassert (go high) on DONE entry.
REQ-027 When the state is IDLE or DONE, MOSI SHALL be held at 0.
REQ-028 A mid-transfer CPOL/CPHA change SHALL be ignored; mode inputs are latched on SETUP entry.

Reset
REQ-029 With Reset=0 at a CLK edge, the block SHALL set:
- state to IDLE;
- SS_n to 1, Busy to 0, R_Valid to 0;
- MOSI to 0, R_Data to 0x00;
- SPI_clk to CPOL;
- the bit counter and divider to 0.
REQ-030 Reset SHALL NOT clear the transmit holding register, so a byte loaded before a reset pulse is transmitted by the next Start.
REQ-031 Reset during XFER SHALL abort the transfer immediately, with no R_Valid pulse.
REQ-032 Reset SHALL take priority over Start and T_Ready.

Configuration
REQ-033 With macro SPI_MASTER_RX_EN defined, MISO capture, R_Data and R_Valid SHALL operate as specified.
REQ-034 With SPI_MASTER_RX_EN undefined, the receive shift logic SHALL be omitted, R_Data SHALL be tied to 0x00, and R_Valid SHALL still pulse on DONE entry.

Verification
REQ-035 Mode 0 MOSI: T_Data=0xA5 with T_Ready pulse, Reset pulse, then Start=0 -> MOSI sampled 1 ns after each SPI_clk rise reads 1,0,1,0,0,1,0,1 (0xA5, LSB first); SS_n low throughout.
REQ-036 Loopback (RX_EN defined): MISO driven with 0x3C LSB first -> R_Data=0x3C and one R_Valid pulse.
REQ-037 CPOL=1, CPHA=1, T_Data=0x81 -> SPI_clk idles high, exactly 8 falling and 8 rising edges, MOSI reads 0x81.
REQ-038 Reset=0 after the 4th bit -> SS_n=1, SPI_clk=CPOL, Busy=0, no R_Valid; a new Start resends the held byte in full.
REQ-039 Start held low for 1000 CLK -> exactly one transfer; raising Start returns to IDLE.
REQ-040 50 sequential random bytes in mode 0 -> every MOSI byte equals T_Data.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: single-byte full-duplex transfer, all four CPOL/CPHA modes,
// LSB first, SPI_clk half-period of CLK_DIV system clocks.
// Optional receive path enabled by defining SPI_MASTER_RX_EN; without it
// R_Data reads 0x00 while R_Valid still marks the end of each transfer.
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] T_Data,
    input  logic       T_Ready,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic       MISO,
    output logic       MOSI,
    output logic       SPI_clk,
    output logic       SS_n,
    output logic       Busy,
    output logic [7:0] R_Data,
    output logic       R_Valid
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_hold;
    logic [7:0] r_tx_sh;
    logic [7:0] r_div;
    logic [4:0] r_edge_cnt;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_ss_n;
    logic       r_rvalid;
    logic       r_cpol;
    logic       r_cpha;

    logic       w_half_end;
    logic       w_last;
    logic       w_edge;
    logic       w_leading;
    logic       w_sample;
    logic       w_shift;
    logic       w_done_entry;

    // SETUP ends with the first SPI_clk edge; XFER then makes the other 15
    // edges and spends one final half-period at the idle level before DONE.
    assign w_half_end   = (r_div == DIV_LAST);
    assign w_last       = (r_edge_cnt == 5'd16);
    assign w_edge       = w_half_end &&
                          ((r_state == SETUP) || ((r_state == XFER) && !w_last));
    assign w_leading    = (r_sclk == r_cpol);
    assign w_sample     = w_edge && (w_leading != r_cpha);
    assign w_shift      = w_edge && (w_leading == r_cpha);
    assign w_done_entry = (r_state == XFER) && w_half_end && w_last;

    // State register
    always_ff @(posedge CLK) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (!Start) w_next = SETUP;
            SETUP: if (w_half_end) w_next = XFER;
            XFER:  if (w_half_end && w_last) w_next = DONE;
            DONE:  if (Start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transmit holding register: loaded only while idle, survives reset
    always_ff @(posedge CLK) begin
        if (Reset && T_Ready && (r_state == IDLE)) r_hold <= T_Data;
    end

    // Clock divider, edge counter, serial clock, MOSI shifter and strobes
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_div      <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= CPOL;
            r_mosi     <= 1'b0;
            r_ss_n     <= 1'b1;
            r_rvalid   <= 1'b0;
            r_cpol     <= CPOL;
            r_cpha     <= CPHA;
            r_tx_sh    <= '0;
        end else begin
            r_rvalid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_mosi <= 1'b0;
                    if (!Start) begin
                        r_tx_sh    <= r_hold;
                        r_mosi     <= r_hold[0];
                        r_ss_n     <= 1'b0;
                        r_cpol     <= CPOL;
                        r_cpha     <= CPHA;
                        r_sclk     <= CPOL;
                        r_div      <= '0;
                        r_edge_cnt <= '0;
                    end
                end
                SETUP, XFER: begin
                    if (w_half_end) r_div <= '0;
                    else            r_div <= r_div + 8'd1;
                    if (w_edge) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 5'd1;
                        // CPHA=0 already shows bit 0, so trailing edges fetch
                        // the next bit; CPHA=1 drives the current bit.
                        if (w_shift) begin
                            r_mosi  <= r_cpha ? r_tx_sh[0] : r_tx_sh[1];
                            r_tx_sh <= {1'b0, r_tx_sh[7:1]};
                        end
                    end
                    if (w_done_entry) begin
                        r_ss_n   <= 1'b1;
                        r_mosi   <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_sclk   <= r_cpol;
                    end
                end
                DONE: r_mosi <= 1'b0;
                default: r_mosi <= 1'b0;
            endcase
        end
    end

`ifdef SPI_MASTER_RX_EN
    logic [7:0] r_rx_sh;
    logic [7:0] r_rdata;

    // Receive shifter (LSB first) and result register
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_rx_sh <= '0;
            r_rdata <= '0;
        end else begin
            if (w_sample)     r_rx_sh <= {MISO, r_rx_sh[7:1]};
            if (w_done_entry) r_rdata <= r_rx_sh;
        end
    end

    assign R_Data = r_rdata;
`else
    logic w_unused;
    assign w_unused = ^{MISO, w_sample};
    assign R_Data   = '0;
`endif

    assign MOSI    = r_mosi;
    assign SS_n    = r_ss_n;
    assign Busy    = (r_state != IDLE);
    assign R_Valid = r_rvalid;
    assign SPI_clk = ((r_state == IDLE) || (r_state == DONE)) ? CPOL : r_sclk;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single-byte transfers with a
// behavioural SPI slave, plus reset, abort, held-Start and random sequences.
module tb_spi_master;

    logic       CLK = 1'b0;
    logic       Reset, Start, T_Ready, CPOL, CPHA, MISO;
    logic [7:0] T_Data;
    logic       MOSI, SPI_clk, SS_n, Busy, R_Valid;
    logic [7:0] R_Data;

    int n_cmp = 0;
    int n_bad = 0;

    spi_master #(.CLK_DIV(2)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .T_Data(T_Data),
        .T_Ready(T_Ready), .CPOL(CPOL), .CPHA(CPHA), .MISO(MISO),
        .MOSI(MOSI), .SPI_clk(SPI_clk), .SS_n(SS_n), .Busy(Busy),
        .R_Data(R_Data), .R_Valid(R_Valid)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] tdata;
        logic       cpol;
        logic       cpha;
        logic [7:0] miso;
        bit         rst_after;
        bit         flip;
        logic [7:0] exp_mosi;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rx_exp(input logic [7:0] m);
`ifdef SPI_MASTER_RX_EN
        return m;
`else
        return 8'h00 & m;
`endif
    endfunction

    // One transfer against a slave model that samples MOSI and drives MISO
    task automatic do_xfer(input logic [7:0] td, input logic cp, input logic ph,
                           input logic [7:0] mi, input bit load, input bit rst_after,
                           input bit flip, output logic [7:0] mosi_b,
                           output logic [7:0] rd, output int nvalid, output int nlead,
                           output int ntrail, output bit ss_bad, output bit tmo,
                           output bit busy_stuck);
        logic prev;
        bit   seen_low;
        CPOL = cp; CPHA = ph; Start = 1'b1; MISO = 1'b0;
        if (load) begin
            T_Data = td; T_Ready = 1'b1; tick(); T_Ready = 1'b0;
        end
        if (rst_after) begin
            Reset = 1'b0; tick(); Reset = 1'b1;
        end
        tick();
        check("idle_sclk", SPI_clk, cp);
        check("idle_mosi", MOSI, 0);
        mosi_b = '0; nvalid = 0; nlead = 0; ntrail = 0;
        ss_bad = 1'b0; tmo = 1'b1; seen_low = 1'b0; busy_stuck = 1'b1;
        prev = SPI_clk;
        Start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (R_Valid) nvalid++;
            if (!SS_n && !seen_low) begin
                seen_low = 1'b1;
                if (!ph) MISO = mi[0];
            end
            if (SPI_clk != prev) begin
                if (SS_n) ss_bad = 1'b1;
                if (SPI_clk != cp) begin
                    if (!ph && nlead < 8) mosi_b[nlead] = MOSI;
                    if (ph && nlead < 8)  MISO = mi[nlead];
                    nlead++;
                    if (flip && nlead == 2) CPHA = ~ph;
                end else begin
                    if (ph && ntrail < 8)  mosi_b[ntrail] = MOSI;
                    if (!ph && ntrail < 7) MISO = mi[ntrail + 1];
                    ntrail++;
                end
                prev = SPI_clk;
            end
            if (seen_low && SS_n) begin
                tmo = 1'b0;
                break;
            end
        end
        repeat (4) begin
            tick();
            if (R_Valid) nvalid++;
        end
        check("done_mosi", MOSI, 0);
        check("done_sclk", SPI_clk, cp);
        rd = R_Data;
        CPHA = ph;
        Start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!Busy) begin
                busy_stuck = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [7:0] td, input logic cp,
                             input logic ph, input logic [7:0] mi, input bit load,
                             input bit rst_after, input bit flip,
                             input logic [7:0] exp_mosi);
        logic [7:0] mb, rd;
        int         nv, nl, nt;
        bit         ssb, tmo, bs;
        do_xfer(td, cp, ph, mi, load, rst_after, flip, mb, rd, nv, nl, nt, ssb, tmo, bs);
        check({tag, "_timeout"}, tmo, 0);
        check({tag, "_mosi"}, mb, exp_mosi);
        check({tag, "_rdata"}, rd, rx_exp(mi));
        check({tag, "_rvalid"}, nv, 1);
        check({tag, "_lead"}, nl, 8);
        check({tag, "_trail"}, nt, 8);
        check({tag, "_ss_low"}, ssb, 0);
        check({tag, "_busy_clr"}, bs, 0);
    endtask

    initial begin
        logic       prev;
        logic       prev_ss;
        int         rises, nv, falls;
        bit         idle_seen;
        logic [7:0] rb, rm;

        Reset = 1'b0; Start = 1'b1; T_Data = '0; T_Ready = 1'b0;
        CPOL = 1'b0; CPHA = 1'b0; MISO = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ss_n", SS_n, 1);
        check("rst_busy", Busy, 0);
        check("rst_rvalid", R_Valid, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_rdata", R_Data, 0);
        check("rst_sclk0", SPI_clk, 0);
        CPOL = 1'b1;
        tick();
        check("rst_sclk1", SPI_clk, 1);
        CPOL = 1'b0;
        Reset = 1'b1;
        tick();

        // Table-driven transfers
        vecs[0] = '{tdata: 8'hA5, cpol: 1'b0, cpha: 1'b0, miso: 8'h3C, rst_after: 1'b1, flip: 1'b0, exp_mosi: 8'hA5};
        vecs[1] = '{tdata: 8'h81, cpol: 1'b1, cpha: 1'b1, miso: 8'hC3, rst_after: 1'b0, flip: 1'b0, exp_mosi: 8'h81};
        vecs[2] = '{tdata: 8'h3C, cpol: 1'b0, cpha: 1'b0, miso: 8'h3C, rst_after: 1'b0, flip: 1'b0, exp_mosi: 8'h3C};
        vecs[3] = '{tdata: 8'h6E, cpol: 1'b0, cpha: 1'b1, miso: 8'h5A, rst_after: 1'b0, flip: 1'b1, exp_mosi: 8'h6E};
        vecs[4] = '{tdata: 8'hF0, cpol: 1'b1, cpha: 1'b0, miso: 8'h0F, rst_after: 1'b0, flip: 1'b1, exp_mosi: 8'hF0};
        vecs[5] = '{tdata: 8'h00, cpol: 1'b0, cpha: 1'b0, miso: 8'hFF, rst_after: 1'b0, flip: 1'b0, exp_mosi: 8'h00};
        for (int i = 0; i < 6; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].tdata, vecs[i].cpol, vecs[i].cpha,
                      vecs[i].miso, 1'b1, vecs[i].rst_after, vecs[i].flip, vecs[i].exp_mosi);
        end

        // Abort mid-transfer after the 4th bit, then resend the held byte
        CPOL = 1'b0; CPHA = 1'b0;
        T_Data = 8'h5B; T_Ready = 1'b1; tick(); T_Ready = 1'b0;
        Start = 1'b0;
        prev = SPI_clk; rises = 0;
        for (int c = 0; c < 200 && rises < 4; c++) begin
            tick();
            if (SPI_clk && !prev) rises++;
            prev = SPI_clk;
        end
        check("abort_reach", rises, 4);
        tick();
        Reset = 1'b0; Start = 1'b1; T_Data = 8'hEE; T_Ready = 1'b1;
        tick();
        T_Ready = 1'b0;
        check("abort_ss_n", SS_n, 1);
        check("abort_sclk", SPI_clk, 0);
        check("abort_busy", Busy, 0);
        check("abort_rvalid", R_Valid, 0);
        check("abort_mosi", MOSI, 0);
        Reset = 1'b1;
        nv = 0;
        repeat (20) begin
            tick();
            nv += int'(R_Valid);
        end
        check("abort_no_valid", nv, 0);
        run_check("resend", 8'h00, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 8'h5B);

        // Start held low for 1000 cycles: one transfer, T_Ready ignored in DONE
        T_Data = 8'h96; T_Ready = 1'b1; tick(); T_Ready = 1'b0;
        Start = 1'b0;
        falls = 0; nv = 0; prev_ss = SS_n;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (prev_ss && !SS_n) falls++;
            prev_ss = SS_n;
            nv += int'(R_Valid);
            if (c == 500) begin
                T_Data = 8'h12; T_Ready = 1'b1;
            end else begin
                T_Ready = 1'b0;
            end
        end
        check("hold_xfers", falls, 1);
        check("hold_rvalid", nv, 1);
        check("hold_busy", Busy, 1);
        check("hold_ss_n", SS_n, 1);
        Start = 1'b1;
        idle_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!Busy) begin
                idle_seen = 1'b1;
                break;
            end
        end
        check("hold_release", idle_seen, 1);
        run_check("after_hold", 8'h00, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h96);

        // Random mode-0 bytes
        for (int i = 0; i < 50; i++) begin
            rb = 8'($urandom_range(0, 255));
            rm = 8'($urandom_range(0, 255));
            run_check($sformatf("rnd%0d", i), rb, 1'b0, 1'b0, rm, 1'b1, 1'b0, 1'b0, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
